param_cache_subsystem: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate cache with an integrated backing data memory. This is the next generation of our cache/memory top. Width, depth and block size are configurable, memory has a configurable multi-cycle latency, misses refill whole multi-word blocks, and hit/miss counters are added. It sits between the RISC-V core's MEM stage and data memory, and stalls the pipeline through `stall`.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_backing_mem.sv | 34 +++
 rtl/param_cache_subsystem.sv | 169 ++++++++++++++++
 tb/tb_param_cache_subsystem.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the parametrised cache subsystem.
// Imported by the cache top and its backing memory.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE_MEM,
        DONE
    } state_t;

    function automatic int offset_w(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_width,
                                 input int words_per_block,
                                 input int num_lines);
        return addr_width - $clog2(words_per_block) - $clog2(num_lines);
    endfunction

    // Counter holds MEM_LATENCY-1 down to 0; a single cycle still needs 1 bit.
    function automatic int lat_w(input int mem_latency);
        return (mem_latency <= 1) ? 1 : $clog2(mem_latency);
    endfunction

endpackage

// File: rtl/cache_backing_mem.sv
// Backing data memory: async clear, synchronous write, combinational read.
// Access latency is modelled by the cache FSM, not here.
import cache_pkg::*;

module cache_backing_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Clear the whole array on reset, otherwise store on the write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/param_cache_subsystem.sv
// Direct-mapped write-through, no-write-allocate cache with backing memory,
// multi-word block refill, multi-cycle memory latency and hit/miss counters.
import cache_pkg::*;

module param_cache_subsystem #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_LINES       = 32,
    parameter int MEM_LATENCY     = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Mem_Write,
    input  logic                  Mem_Read,
    input  logic [ADDR_WIDTH-1:0] Word_address,
    input  logic [DATA_WIDTH-1:0] Data_In,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int OFFSET_W = offset_w(WORDS_PER_BLOCK);
    localparam int INDEX_W  = index_w(NUM_LINES);
    localparam int TAG_W    = tag_w(ADDR_WIDTH, WORDS_PER_BLOCK, NUM_LINES);
    localparam int LAT_W    = lat_w(MEM_LATENCY);
    localparam int WORDS    = NUM_LINES * WORDS_PER_BLOCK;

    localparam logic [LAT_W-1:0]    LAT_MAX   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_BLOCK - 1);

    state_t state;

    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tag_array  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_array [WORDS];

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [LAT_W-1:0]      lat_cnt;
    logic [OFFSET_W-1:0]   word_cnt;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [TAG_W-1:0]    r_tag;
    logic [INDEX_W-1:0]  r_index;
    logic [OFFSET_W-1:0] r_offset;

    logic                  hit;
    logic                  fill_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] req_word;

    assign {tag, index, offset}       = Word_address;
    assign {r_tag, r_index, r_offset} = req_addr;

    assign hit = valid[index] && (tag_array[index] == tag);

    // Reset forces stall low at once, even with a request still held.
    assign stall = !rst &&
                   ((state == IDLE && (Mem_Write || (Mem_Read && !hit))) ||
                    state == REFILL || state == WRITE_MEM);

    assign fill_word = (state == REFILL) && (lat_cnt == '0);
    assign mem_we    = (state == WRITE_MEM) && (lat_cnt == '0);
    assign mem_addr  = (state == REFILL) ? {r_tag, r_index, word_cnt} : req_addr;

    // The requested word may be the one arriving now or one already filled.
    assign req_word = (word_cnt == r_offset) ? mem_rdata
                                             : data_array[{r_index, r_offset}];

    cache_backing_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(req_data),
        .rdata(mem_rdata)
    );

    // Cache storage: write hits update in place, refill words land as fetched.
    always_ff @(posedge clk) begin
        if (state == IDLE && Mem_Write && hit) begin
            data_array[{index, offset}] <= Data_In;
        end else if (fill_word) begin
            data_array[{r_index, word_cnt}] <= mem_rdata;
        end
        if (fill_word && word_cnt == LAST_WORD) begin
            tag_array[r_index] <= r_tag;
        end
    end

    // Control FSM with valid bits, read data and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            Data_Out   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            lat_cnt    <= '0;
            word_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Mem_Write) begin
                        req_addr <= Word_address;
                        req_data <= Data_In;
                        lat_cnt  <= LAT_MAX;
                        state    <= WRITE_MEM;
                    end else if (Mem_Read) begin
                        if (hit) begin
                            Data_Out <= data_array[{index, offset}];
                            if (hit_count != '1) begin
                                hit_count <= hit_count + 1'b1;
                            end
                        end else begin
                            req_addr     <= Word_address;
                            lat_cnt      <= LAT_MAX;
                            word_cnt     <= '0;
                            valid[index] <= 1'b0;
                            if (miss_count != '1) begin
                                miss_count <= miss_count + 1'b1;
                            end
                            state <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (lat_cnt == '0) begin
                        lat_cnt  <= LAT_MAX;
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            valid[r_index] <= 1'b1;
                            Data_Out       <= req_word;
                            state          <= DONE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                WRITE_MEM: begin
                    if (lat_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_cache_subsystem.sv
// Directed table-driven bench for param_cache_subsystem (default parameters),
// plus hand sequences for reset-during-refill and counter saturation.
module tb_param_cache_subsystem;

    logic        clk = 1'b0;
    logic        rst;
    logic        Mem_Write;
    logic        Mem_Read;
    logic [9:0]  Word_address;
    logic [31:0] Data_In;
    logic        stall;
    logic [31:0] Data_Out;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_cache_subsystem dut (
        .clk         (clk),
        .rst         (rst),
        .Mem_Write   (Mem_Write),
        .Mem_Read    (Mem_Read),
        .Word_address(Word_address),
        .Data_In     (Data_In),
        .stall       (stall),
        .Data_Out    (Data_Out),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        int          exp_stall;
        logic [31:0] exp_dout;
        logic [15:0] exp_hits;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Count stall cycles of the request now on the inputs, then let it be
    // consumed at the next edge and drop the request.
    task automatic run(output int ns);
        ns = 0;
        #1;
        while (stall === 1'b1 && ns < 200) begin
            ns++;
            @(negedge clk);
            #1;
        end
        if (ns >= 200) begin
            errors++;
            $display("FAIL timeout: stall high for %0d cycles, expected release", ns);
        end
        @(posedge clk);
        #1;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [9:0] a,
                      input logic [31:0] d, output int ns);
        @(negedge clk);
        Mem_Read     = rd;
        Mem_Write    = wr;
        Word_address = a;
        Data_In      = d;
        run(ns);
    endtask

    initial begin
        int ns;

        vecs[0]  = '{1'b1, 1'b0, 10'h000, 32'h0,        17, 32'h0,        16'd0, 16'd1};
        vecs[1]  = '{1'b0, 1'b1, 10'h005, 32'h12345678,  5, 32'h0,        16'd0, 16'd1};
        vecs[2]  = '{1'b1, 1'b0, 10'h005, 32'h0,        17, 32'h12345678, 16'd0, 16'd2};
        vecs[3]  = '{1'b1, 1'b0, 10'h006, 32'h0,         0, 32'h0,        16'd1, 16'd2};
        vecs[4]  = '{1'b0, 1'b1, 10'h006, 32'hDEADBEEF,  5, 32'h0,        16'd1, 16'd2};
        vecs[5]  = '{1'b1, 1'b0, 10'h006, 32'h0,         0, 32'hDEADBEEF, 16'd2, 16'd2};
        vecs[6]  = '{1'b1, 1'b0, 10'h086, 32'h0,        17, 32'h0,        16'd2, 16'd3};
        vecs[7]  = '{1'b1, 1'b0, 10'h006, 32'h0,        17, 32'hDEADBEEF, 16'd2, 16'd4};
        vecs[8]  = '{1'b1, 1'b0, 10'h000, 32'h0,         0, 32'h0,        16'd3, 16'd4};
        vecs[9]  = '{1'b1, 1'b1, 10'h007, 32'hCAFEF00D,  5, 32'h0,        16'd3, 16'd4};
        vecs[10] = '{1'b1, 1'b0, 10'h007, 32'h0,         0, 32'hCAFEF00D, 16'd4, 16'd4};
        vecs[11] = '{1'b0, 1'b1, 10'h3FF, 32'hA5A5A5A5,  5, 32'hCAFEF00D, 16'd4, 16'd4};
        vecs[12] = '{1'b1, 1'b0, 10'h3FF, 32'h0,        17, 32'hA5A5A5A5, 16'd4, 16'd5};
        vecs[13] = '{1'b1, 1'b0, 10'h3FC, 32'h0,         0, 32'h0,        16'd5, 16'd5};
        vecs[14] = '{1'b1, 1'b0, 10'h007, 32'h0,         0, 32'hCAFEF00D, 16'd6, 16'd5};

        rst          = 1'b1;
        Mem_Read     = 1'b0;
        Mem_Write    = 1'b0;
        Word_address = '0;
        Data_In      = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset dout", Data_Out, 32'h0);
        check("reset hits", 32'(hit_count), 32'd0);
        check("reset misses", 32'(miss_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, ns);
            check($sformatf("v%0d stall", i), 32'(ns), 32'(vecs[i].exp_stall));
            check($sformatf("v%0d dout", i), Data_Out, vecs[i].exp_dout);
            check($sformatf("v%0d hits", i), 32'(hit_count), 32'(vecs[i].exp_hits));
            check($sformatf("v%0d misses", i), 32'(miss_count), 32'(vecs[i].exp_miss));
        end

        // Reset in the 8th refill cycle of a miss on a fresh line.
        @(negedge clk);
        Mem_Read     = 1'b1;
        Word_address = 10'h040;
        repeat (8) @(posedge clk);
        #1;
        check("mid refill stall", 32'(stall), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort stall", 32'(stall), 32'd0);
        check("abort dout", Data_Out, 32'h0);
        check("abort hits", 32'(hit_count), 32'd0);
        check("abort misses", 32'(miss_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(ns);
        check("reread stall", 32'(ns), 32'd17);
        check("reread dout", Data_Out, 32'h0);
        check("reread misses", 32'(miss_count), 32'd1);
        check("reread hits", 32'(hit_count), 32'd0);

        // Held read on a hit line scores one hit per cycle.
        @(negedge clk);
        Mem_Read     = 1'b1;
        Word_address = 10'h040;
        repeat (65534) @(posedge clk);
        #1;
        Mem_Read = 1'b0;
        check("hits near max", 32'(hit_count), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            op(1'b1, 1'b0, 10'h041, 32'h0, ns);
            check($sformatf("sat hit%0d stall", k), 32'(ns), 32'd0);
        end
        check("hits saturated", 32'(hit_count), 32'hFFFF);
        check("misses after sat", 32'(miss_count), 32'd1);

        op(1'b1, 1'b1, 10'h041, 32'h11111111, ns);
        check("rw stall", 32'(ns), 32'd5);
        check("rw dout", Data_Out, 32'h0);
        check("rw hits", 32'(hit_count), 32'hFFFF);
        check("rw misses", 32'(miss_count), 32'd1);

        op(1'b1, 1'b0, 10'h041, 32'h0, ns);
        check("post rw stall", 32'(ns), 32'd0);
        check("post rw dout", Data_Out, 32'h11111111);
        check("hits stay max", 32'(hit_count), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
